// File: rtl/multi_pulse_timer.sv
// multi_pulse_timer
//   Measures the width of pulses on NCH independent asynchronous inputs in
//   whole milliseconds and hands the results out one at a time through a
//   registered valid/ack port shared by all channels.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   pulse_in   asynchronous pulse inputs, one per channel
//   polarity   per-channel measured level: 0 = high pulse, 1 = low pulse
//   enable     global measurement enable
//   res_valid  a result is presented on res_ch / res_ms / res_ovf
//   res_ack    consumer accepts the presented result
//   res_ch     channel index of the presented result
//   res_ms     measured width in whole milliseconds (saturating)
//   res_ovf    the measurement saturated
//   busy       channel is measuring or holding a result
//   overrun    sticky: a start edge arrived while the channel held a result
module multi_pulse_timer #(
    parameter int NCH        = 4,
    parameter int CLK_PER_MS = 50000,
    parameter int MS_W       = 16,
    localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  pulse_in,
    input  logic [NCH-1:0]  polarity,
    input  logic            enable,
    output logic            res_valid,
    input  logic            res_ack,
    output logic [CW-1:0]   res_ch,
    output logic [MS_W-1:0] res_ms,
    output logic            res_ovf,
    output logic [NCH-1:0]  busy,
    output logic [NCH-1:0]  overrun
);

    localparam int PW = $clog2(CLK_PER_MS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_MS - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, HOLD} state_t;

    logic [NCH-1:0]  hold_vec;
    logic [NCH-1:0]  hold_ovf;
    logic [MS_W-1:0] hold_ms [NCH];
    logic            accept;
    logic [2:0]      sync_fill;

    assign accept = res_valid & res_ack;

    // The synchronizers come out of reset holding zeros, so until a real
    // sample has reached the delayed copy the edge detector would see a
    // phantom transition on any input that is already active.  Edges are
    // therefore ignored until three samples have been clocked through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_fill <= '0;
        else     sync_fill <= {sync_fill[1:0], 1'b1};
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic            s0, s1, s_d;
        logic            act_now, act_prev, start_edge, end_edge;
        logic            wrap, ms_sat, ovf_flag, ovf_upd, ovr, release_ch;
        logic [PW-1:0]   presc;
        logic [MS_W-1:0] ms_cnt, ms_upd;
        state_t          state, state_next;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s0  <= 1'b0;
                s1  <= 1'b0;
                s_d <= 1'b0;
            end else begin
                s0  <= pulse_in[g];
                s1  <= s0;
                s_d <= s1;
            end
        end

        // Both samples are XORed with the same polarity bit, so changing
        // polarity alone never looks like an edge.
        assign act_now    = s1 ^ polarity[g];
        assign act_prev   = s_d ^ polarity[g];
        assign start_edge = sync_fill[2] & act_now & ~act_prev;
        assign end_edge   = sync_fill[2] & ~act_now & act_prev;
        assign release_ch = accept && (res_ch == CW'(g));

        // The end-edge cycle still counts as a measuring cycle, so the
        // stored result is the counter value after that cycle's update.
        assign wrap    = (presc == PRESC_MAX);
        assign ms_sat  = &ms_cnt;
        assign ms_upd  = (wrap && !ms_sat) ? ms_cnt + 1'b1 : ms_cnt;
        assign ovf_upd = ovf_flag | (wrap & ms_sat);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) state <= IDLE;
            else     state <= state_next;
        end

        always_comb begin
            state_next = state;
            case (state)
                IDLE:    if (start_edge && enable) state_next = MEASURE;
                MEASURE: begin
                    if (!enable)       state_next = IDLE;
                    else if (end_edge) state_next = HOLD;
                end
                HOLD:    if (release_ch) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                presc    <= '0;
                ms_cnt   <= '0;
                ovf_flag <= 1'b0;
            end else if (state == IDLE && state_next == MEASURE) begin
                presc    <= '0;
                ms_cnt   <= '0;
                ovf_flag <= 1'b0;
            end else if (state == MEASURE) begin
                presc    <= wrap ? '0 : presc + 1'b1;
                ms_cnt   <= ms_upd;
                ovf_flag <= ovf_upd;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)                              ovr <= 1'b0;
            else if (state == HOLD && start_edge) ovr <= 1'b1;
        end

        assign busy[g]     = (state != IDLE);
        assign hold_vec[g] = (state == HOLD);
        assign hold_ms[g]  = ms_cnt;
        assign hold_ovf[g] = ovf_flag;
        assign overrun[g]  = ovr;
    end

    // Round-robin search starting at ptr.  The channel being accepted this
    // cycle is still in HOLD, so it is masked out to avoid re-presenting it.
    logic [CW-1:0]  ptr, pick;
    logic [NCH-1:0] eligible;
    logic           found;

    always_comb begin
        int k;
        k     = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NCH; i++) begin
            eligible[i] = hold_vec[i] && !(res_valid && res_ch == CW'(i));
        end
        for (int i = 0; i < NCH; i++) begin
            k = int'(ptr) + i;
            if (k >= NCH) k = k - NCH;
            if (!found && eligible[k]) begin
                found = 1'b1;
                pick  = CW'(k);
            end
        end
    end

    // The output register only reloads when it is empty or being accepted,
    // which keeps the presented result stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_ms    <= '0;
            res_ovf   <= 1'b0;
            ptr       <= '0;
        end else if (!res_valid || res_ack) begin
            res_valid <= found;
            if (found) begin
                res_ch  <= pick;
                res_ms  <= hold_ms[pick];
                res_ovf <= hold_ovf[pick];
                ptr     <= (pick == CW'(NCH - 1)) ? '0 : pick + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_pulse_timer.sv
// tb_multi_pulse_timer
//   Directed bench for multi_pulse_timer with CLK_PER_MS=10, MS_W=4, NCH=4.
//   Expected values are hand-computed pulse widths in milliseconds.
module tb_multi_pulse_timer;

    logic       clk;
    logic       rst;
    logic [3:0] pulse_in;
    logic [3:0] polarity;
    logic       enable;
    logic       res_valid;
    logic       res_ack;
    logic [1:0] res_ch;
    logic [3:0] res_ms;
    logic       res_ovf;
    logic [3:0] busy;
    logic [3:0] overrun;

    int checkCount;
    int errorCount;

    multi_pulse_timer #(
        .NCH(4),
        .CLK_PER_MS(10),
        .MS_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pulse_in(pulse_in),
        .polarity(polarity),
        .enable(enable),
        .res_valid(res_valid),
        .res_ack(res_ack),
        .res_ch(res_ch),
        .res_ms(res_ms),
        .res_ovf(res_ovf),
        .busy(busy),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drives the channels in mask to their active level for len cycles.
    task automatic applyStimulus(input logic [3:0] mask, input int len);
        for (int i = 0; i < 4; i++) if (mask[i]) pulse_in[i] = ~polarity[i];
        repeat (len) tick();
        for (int i = 0; i < 4; i++) if (mask[i]) pulse_in[i] = polarity[i];
    endtask

    task automatic waitValid(input int maxCyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic watchNoValid(input int n, output bit extra);
        extra = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (res_valid) extra = 1'b1;
            tick();
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        bit         seen, extra, stable;
        logic [1:0] capCh;
        logic [3:0] capMs;
        logic       capOvf;

        checkCount = 0;
        errorCount = 0;
        rst        = 1'b1;
        polarity   = 4'b0010;
        pulse_in   = 4'b0010;
        enable     = 1'b1;
        res_ack    = 1'b1;
        repeat (3) tick();

        checkOutput("rst_valid", res_valid, 0);
        checkOutput("rst_ch", res_ch, 0);
        checkOutput("rst_ms", res_ms, 0);
        checkOutput("rst_ovf", res_ovf, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_overrun", overrun, 0);
        rst = 1'b0;
        repeat (5) tick();

        // ch0 high pulse of 35 clk -> 3 ms
        pulse_in[0] = 1'b1;
        repeat (10) tick();
        checkOutput("p35_busy", busy, 4'b0001);
        repeat (25) tick();
        pulse_in[0] = 1'b0;
        waitValid(20, seen);
        checkOutput("p35_seen", seen, 1);
        checkOutput("p35_ch", res_ch, 0);
        checkOutput("p35_ms", res_ms, 3);
        checkOutput("p35_ovf", res_ovf, 0);
        tick();
        watchNoValid(10, extra);
        checkOutput("p35_single", extra, 0);
        checkOutput("p35_idle", busy, 0);

        // ch1 low pulse of 20 clk -> 2 ms
        applyStimulus(4'b0010, 20);
        waitValid(20, seen);
        checkOutput("p20_seen", seen, 1);
        checkOutput("p20_ch", res_ch, 1);
        checkOutput("p20_ms", res_ms, 2);
        checkOutput("p20_ovf", res_ovf, 0);
        repeat (5) tick();

        // ch2 high pulse of 200 clk -> saturated at 15 with overflow
        applyStimulus(4'b0100, 200);
        waitValid(20, seen);
        checkOutput("p200_seen", seen, 1);
        checkOutput("p200_ch", res_ch, 2);
        checkOutput("p200_ms", res_ms, 15);
        checkOutput("p200_ovf", res_ovf, 1);
        repeat (5) tick();

        // ch0 and ch3 end together; pointer back at 0 after reset
        applyReset();
        applyStimulus(4'b1001, 25);
        waitValid(20, seen);
        checkOutput("dual_seen", seen, 1);
        checkOutput("dual_first_ch", res_ch, 0);
        checkOutput("dual_first_ms", res_ms, 2);
        tick();
        checkOutput("dual_second_valid", res_valid, 1);
        checkOutput("dual_second_ch", res_ch, 3);
        checkOutput("dual_second_ms", res_ms, 2);
        tick();
        checkOutput("dual_done_valid", res_valid, 0);
        checkOutput("dual_done_busy", busy, 0);

        // stalled consumer while ch0 holds; second pulse is an overrun
        res_ack = 1'b0;
        applyStimulus(4'b0001, 15);
        waitValid(20, seen);
        checkOutput("stall_seen", seen, 1);
        checkOutput("stall_ch", res_ch, 0);
        checkOutput("stall_ms", res_ms, 1);
        capCh  = res_ch;
        capMs  = res_ms;
        capOvf = res_ovf;
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (c == 5)  pulse_in[0] = 1'b1;
            if (c == 25) pulse_in[0] = 1'b0;
            if (!res_valid || res_ch != capCh || res_ms != capMs || res_ovf != capOvf)
                stable = 1'b0;
            tick();
        end
        checkOutput("stall_stable", stable, 1);
        checkOutput("stall_overrun", overrun, 4'b0001);
        res_ack = 1'b1;
        tick();
        checkOutput("stall_acked_valid", res_valid, 0);
        watchNoValid(20, extra);
        checkOutput("stall_no_extra", extra, 0);
        checkOutput("stall_busy", busy, 0);
        checkOutput("stall_overrun_sticky", overrun, 4'b0001);

        // reset in the middle of a 30 clk pulse discards it
        pulse_in[0] = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        #2;
        checkOutput("midrst_valid", res_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_overrun", overrun, 0);
        tick();
        rst = 1'b0;
        repeat (19) tick();
        pulse_in[0] = 1'b0;
        watchNoValid(20, extra);
        checkOutput("midrst_no_stale", extra, 0);
        checkOutput("midrst_idle", busy, 0);
        applyStimulus(4'b0001, 40);
        waitValid(20, seen);
        checkOutput("p40_seen", seen, 1);
        checkOutput("p40_ch", res_ch, 0);
        checkOutput("p40_ms", res_ms, 4);
        checkOutput("p40_ovf", res_ovf, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/multi_pulse_timer.md
MULTI_PULSE_TIMER -- requirements
Module: multi_pulse_timer

Interface
REQ-001 Parameter NCH, 4, number of independent pulse-input channels (1..16).
REQ-002 Parameter CLK_PER_MS, 50000, clk cycles per millisecond (>=2).
REQ-003 Parameter MS_W, 16, width of the millisecond result (1..32).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 pulse_in  in  NCH  asynchronous pulse inputs, one per channel.
REQ-007 polarity  in  NCH  per-channel measured level: 0 = high pulse, 1 = low pulse.
REQ-008 enable  in  1  global measurement enable.
REQ-009 res_valid  out  1  result available on res_* outputs.
REQ-010 res_ack  in  1  consumer accepts the result when res_valid=1.
REQ-011 res_ch  out  clog2(NCH) (min 1)  channel index of the presented result.
REQ-012 res_ms  out  MS_W  measured width in whole milliseconds.
REQ-013 res_ovf  out  1  measurement saturated.
REQ-014 busy  out  NCH  channel in MEASURE or HOLD.
REQ-015 overrun  out  NCH  sticky: a start edge was lost while the channel was in HOLD.

Function
REQ-016 Each pulse_in bit SHALL pass through a 2-flop synchronizer; edge detection SHALL compare the synchronized value with its one-cycle-delayed copy.
REQ-017 The active level SHALL be sync XOR polarity; start edge = inactive->active, end edge = active->inactive.
REQ-018 Each channel SHALL run an FSM with states IDLE, MEASURE, HOLD.
REQ-019 IDLE: on a start edge with enable=1, the channel SHALL clear its prescaler and ms counter and enter MEASURE in the next cycle.
REQ-020 MEASURE: prescaler SHALL count 0..CLK_PER_MS-1 and wrap; each wrap SHALL increment the ms counter.
REQ-021 The ms counter SHALL saturate at 2^MS_W-1; an increment attempted at saturation SHALL set the channel ovf flag.
REQ-022 MEASURE: on an end edge, the channel SHALL latch ms counter and ovf and enter HOLD; res_ms = floor(cycles in MEASURE / CLK_PER_MS).
REQ-023 MEASURE with enable=0: the channel SHALL return to IDLE and produce no result.
REQ-024 HOLD: the channel SHALL keep its result until it is accepted, then return to IDLE; edges in HOLD SHALL NOT start a measurement.
REQ-025 A start edge detected in HOLD SHALL set overrun[ch]; overrun SHALL clear only on reset.
REQ-026 After leaving HOLD, a channel whose input is still active SHALL wait for a fresh start edge.
REQ-027 The output port SHALL be a registered round-robin arbiter over channels in HOLD; priority SHALL start after the last granted channel and be index 0 after reset.
REQ-028 A result SHALL be accepted when res_valid=1 and res_ack=1 in the same cycle; a new result MAY be presented in the next cycle.
REQ-029 While res_valid=1 and res_ack=0, res_ch, res_ms and res_ovf SHALL hold stable.
REQ-030 Latency: end edge detected in cycle T -> HOLD at T+1 -> res_valid at T+2 at the earliest.
REQ-031 Simultaneous end edges on several channels SHALL lose no result; they SHALL be presented one per accepted handshake in round-robin order.
REQ-032 enable SHALL NOT affect results already in HOLD.

Reset
REQ-033 rst=1 SHALL force all channels to IDLE; clear counters, synchronizers, the arbiter pointer, busy and overrun; and set res_valid=0, res_ch=0, res_ms=0, res_ovf=0, all asynchronously.
REQ-034 rst asserted mid-measurement SHALL discard that measurement; no stale result appears after release.

Verification (CLK_PER_MS=10, MS_W=4, NCH=4)
REQ-035 ch0 polarity=0, high pulse of 35 clk, res_ack=1 -> one result: res_ch=0, res_ms=3, res_ovf=0.
REQ-036 ch1 polarity=1, low pulse of 20 clk -> res_ch=1, res_ms=2, res_ovf=0.
REQ-037 ch2 high pulse of 200 clk -> res_ms=15, res_ovf=1.
REQ-038 Pulses on ch0 and ch3 end in the same cycle, res_ack=1 -> ch0 result, then ch3 result in the next cycle; ch0 and ch3 busy then clear.
REQ-039 res_ack=0 for 50 cycles while ch0 holds a result, second ch0 pulse starts -> res_* stable, overrun[0]=1, no extra result after ack.
REQ-040 rst pulsed during a 30 clk pulse on ch0 -> res_valid=0, busy=0; a following 40 clk pulse gives res_ms=4.
